// File: rtl/serial_parallel_rx_pkg.sv
// Shared definitions for the serial-to-parallel receiver: FSM states and
// the default frame width.
package serial_parallel_rx_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_parallel_rx_shift_reg_sipo.sv
// Serial-in, shift-right register. New bits enter at the MSB so that an
// LSB-first stream ends up in natural bit order after WIDTH shifts.
module shift_reg_sipo
   import serial_parallel_rx_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             din,
   output logic [WIDTH-1:0] q
);

   // Shift right on enable, inserting the serial bit at the top.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (en) begin
         q <= {din, q[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/serial_parallel_rx.sv
// Serial-to-parallel frame receiver. A start pulse marks bit 0 of a frame;
// WIDTH bits later the assembled word is published on ParOutput with a
// one-cycle valid pulse. The receiver is ready for a new start in the very
// cycle valid is high, so frames can run back to back.
module serial_parallel_rx
   import serial_parallel_rx_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             SerInput,
   output logic [WIDTH-1:0] ParOutput,
   output logic             valid,
   output logic             busy
);

   localparam int              CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

   state_t           state_reg;
   state_t           state_next;
   logic [CW-1:0]    cnt_reg;
   logic [CW-1:0]    cnt_next;
   logic             shift_en;
   logic             frame_done;
   logic [WIDTH-1:0] shift_q;
   logic             shift_lsb_unused;

   // Bit 0 of the shift register is never needed: at completion the
   // final bit is taken straight from SerInput and the rest from [W-1:1].
   assign shift_lsb_unused = shift_q[0];

   shift_reg_sipo #(
      .WIDTH (WIDTH)
   ) u_shift (
      .clk   (clk),
      .reset (reset),
      .en    (shift_en),
      .din   (SerInput),
      .q     (shift_q)
   );

   // Next-state, counter and datapath control.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      shift_en   = 1'b0;
      frame_done = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               shift_en   = 1'b1;
               cnt_next   = CW'(1);
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (cnt_reg == LAST_BIT) begin
               // Counter is held here so it never wraps inside a frame.
               frame_done = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State and bit counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Publish the completed word and raise valid for one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ParOutput <= '0;
         valid     <= 1'b0;
      end else begin
         valid <= frame_done;
         if (frame_done) begin
            ParOutput <= {SerInput, shift_q[WIDTH-1:1]};
         end
      end
   end

   // busy follows the registered state only, so start has no path to it.
   assign busy = (state_reg == SHIFT);

endmodule

// File: tb/tb_serial_parallel_rx.sv
// Testbench for serial_parallel_rx: a directed vector table, hand-written
// corner sequences and a randomized run against a bit-queue frame model.
module tb_serial_parallel_rx;

   localparam int W = 4;

   typedef struct {
      logic         s;
      logic         d;
      logic [W-1:0] par;
      logic         v;
      logic         b;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         SerInput;
   logic [W-1:0] ParOutput;
   logic         valid;
   logic         busy;

   int tests       = 0;
   int fails       = 0;
   int cycle       = 0;
   int valid_count = 0;

   // Reference model: collected bits of the frame in progress.
   logic         model_q[$];
   bit           collecting;
   logic [W-1:0] m_par;
   logic         m_valid;
   logic         m_busy;

   vec_t vecs[5];

   serial_parallel_rx #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .SerInput  (SerInput),
      .ParOutput (ParOutput),
      .valid     (valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic model_reset();
      collecting = 1'b0;
      model_q.delete();
      m_par   = '0;
      m_valid = 1'b0;
      m_busy  = 1'b0;
   endtask

   // One rising edge of the model: gather bits, emit a word after W of them.
   task automatic model_edge(input logic s, input logic d);
      m_valid = 1'b0;
      if (collecting) begin
         model_q.push_back(d);
      end else if (s) begin
         collecting = 1'b1;
         model_q.delete();
         model_q.push_back(d);
      end
      if (collecting && model_q.size() == W) begin
         for (int i = 0; i < W; i++) m_par[i] = model_q[i];
         m_valid    = 1'b1;
         collecting = 1'b0;
      end
      m_busy = collecting;
   endtask

   task automatic drive(input logic s, input logic d);
      start    = s;
      SerInput = d;
      @(posedge clk);
      #1;
      cycle++;
      model_edge(s, d);
      if (valid) begin
         valid_count++;
         $display("[TB] cycle %0d frame 0x%0h", cycle, ParOutput);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, " par"},   32'(ParOutput), 32'(m_par));
      chk({tag, " valid"}, 32'(valid),     32'(m_valid));
      chk({tag, " busy"},  32'(busy),      32'(m_busy));
   endtask

   task automatic send_frame(input logic [W-1:0] value, input logic start_every);
      for (int i = 0; i < W; i++) drive((i == 0) ? 1'b1 : start_every, value[i]);
   endtask

   initial begin
      int t1;
      int v0;
      logic [W-1:0] tx;

      model_reset();
      reset    = 1'b1;
      start    = 1'b0;
      SerInput = 1'b0;
      @(posedge clk);
      #1;
      chk("reset par",   32'(ParOutput), 32'h0);
      chk("reset valid", 32'(valid),     32'h0);
      chk("reset busy",  32'(busy),      32'h0);
      reset = 1'b0;

      // Bits 1,1,0,1 LSB first -> 4'b1011; start in first cycle after reset.
      vecs[0] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 1'b1, 4'hB, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 4'hB, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         drive(vecs[i].s, vecs[i].d);
         $display("[TB] vec%0d start=%0b ser=%0b par=0x%0h valid=%0b busy=%0b",
                  i, vecs[i].s, vecs[i].d, ParOutput, valid, busy);
         chk($sformatf("vec%0d par", i),   32'(ParOutput), 32'(vecs[i].par));
         chk($sformatf("vec%0d valid", i), 32'(valid),     32'(vecs[i].v));
         chk($sformatf("vec%0d busy", i),  32'(busy),      32'(vecs[i].b));
      end

      // Back-to-back 0x5 then 0xA, second start in the valid cycle.
      v0 = valid_count;
      send_frame(4'h5, 1'b0);
      chk("b2b first par",   32'(ParOutput), 32'h5);
      chk("b2b first valid", 32'(valid),     32'h1);
      t1 = cycle;
      send_frame(4'hA, 1'b0);
      chk("b2b second par",   32'(ParOutput), 32'hA);
      chk("b2b second valid", 32'(valid),     32'h1);
      chk("b2b spacing",      32'(cycle - t1), 32'd4);
      chk("b2b pulses",       32'(valid_count - v0), 32'd2);

      // start held high through SHIFT of 0x3 must be ignored.
      v0 = valid_count;
      send_frame(4'h3, 1'b1);
      drive(1'b0, 1'b0);
      chk("ignore start par",    32'(ParOutput), 32'h3);
      chk("ignore start pulses", 32'(valid_count - v0), 32'd1);
      check_model("ignore start");

      // Frame 0xF aborted by async reset mid-clock after bit 2.
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b1);
      #3;
      reset = 1'b1;
      #1;
      chk("async rst par",   32'(ParOutput), 32'h0);
      chk("async rst valid", 32'(valid),     32'h0);
      chk("async rst busy",  32'(busy),      32'h0);
      model_reset();
      start    = 1'b1;
      SerInput = 1'b1;
      @(posedge clk);
      #1;
      chk("edge in rst busy", 32'(busy),  32'h0);
      chk("edge in rst valid", 32'(valid), 32'h0);
      reset = 1'b0;
      v0 = valid_count;
      send_frame(4'h6, 1'b0);
      chk("after rst par",    32'(ParOutput), 32'h6);
      chk("after rst valid",  32'(valid),     32'h1);
      chk("after rst pulses", 32'(valid_count - v0), 32'd1);

      // Idle line noise after 0x9 must not disturb the held output.
      send_frame(4'h9, 1'b0);
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, i[0]);
         chk("idle par",   32'(ParOutput), 32'h9);
         chk("idle valid", 32'(valid),     32'h0);
         chk("idle busy",  32'(busy),      32'h0);
      end

      // Loopback from a parallel-load shift-right transmitter holding 0xC.
      tx = 4'hC;
      for (int i = 0; i < W; i++) begin
         drive(i == 0, tx[0]);
         tx = tx >> 1;
      end
      chk("loopback par",   32'(ParOutput), 32'hC);
      chk("loopback valid", 32'(valid),     32'h1);

      // Randomized traffic with occasional mid-cycle resets.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 2) == 0, 1'($urandom));
         check_model("rnd");
         if ($urandom_range(0, 49) == 0) begin
            #2;
            reset = 1'b1;
            #2;
            reset = 1'b0;
            model_reset();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
